// File: rtl/fb_fill_arbiter.sv
// fb_fill_arbiter
//   Shares the single framebuffer write port of vga_controller_mod between
//   NUM_REQ requesters. Each requester asks for a solid-colour rectangle
//   fill in physical pixel coordinates; a round-robin arbiter grants one
//   request at a time and a raster sequencer emits one pixel write per clock.
//
// Ports
//   iCLK, iRST_n   clock, asynchronous active-low reset
//   ireq           per-requester fill request (level)
//   itlx/itly      packed top-left corner, requester i at slice i
//   ibrx/ibry      packed bottom-right corner (inclusive)
//   icolor         packed fill colour
//   oack           one-cycle pulse when the request has been latched
//   odone          one-cycle pulse after the last pixel has been written
//   obusy          high whenever the sequencer is not idle
//   owren/oaddr/odata  framebuffer write port (addr = y*H_PIXELS + x)
//
// Build option
//   FB_FILL_CLIP_EN  when defined, the bottom-right corner is clamped to
//                    (H_PHY_MAX, V_PHY_MAX) at load time and an empty
//                    rectangle skips straight to DONE with zero writes.

module fb_fill_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int H_PHY_WIDTH    = 10,
  parameter int V_PHY_WIDTH    = 9,
  parameter int H_PIXELS       = 640,
  parameter int H_PHY_MAX      = 639,
  parameter int V_PHY_MAX      = 479,
  parameter int VGA_ADDR_WIDTH = 19,
  parameter int COLOR_ID_WIDTH = 8
) (
  input  logic                                iCLK,
  input  logic                                iRST_n,
  input  logic [NUM_REQ-1:0]                  ireq,
  input  logic [NUM_REQ*H_PHY_WIDTH-1:0]      itlx,
  input  logic [NUM_REQ*V_PHY_WIDTH-1:0]      itly,
  input  logic [NUM_REQ*H_PHY_WIDTH-1:0]      ibrx,
  input  logic [NUM_REQ*V_PHY_WIDTH-1:0]      ibry,
  input  logic [NUM_REQ*COLOR_ID_WIDTH-1:0]   icolor,
  output logic [NUM_REQ-1:0]                  oack,
  output logic [NUM_REQ-1:0]                  odone,
  output logic                                obusy,
  output logic                                owren,
  output logic [VGA_ADDR_WIDTH-1:0]           oaddr,
  output logic [COLOR_ID_WIDTH-1:0]           odata
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int AW = VGA_ADDR_WIDTH;
  localparam logic [31:0] HP_BITS = 32'(H_PIXELS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                     state_q, state_d;
  logic [GW-1:0]              g_q, g_d;
  logic [GW-1:0]              last_q, last_d;
  logic [H_PHY_WIDTH-1:0]     tlx_q, tlx_d;
  logic [H_PHY_WIDTH-1:0]     brx_q, brx_d;
  logic [V_PHY_WIDTH-1:0]     bry_q, bry_d;
  logic [COLOR_ID_WIDTH-1:0]  color_q, color_d;
  logic [H_PHY_WIDTH-1:0]     x_q, x_d;
  logic [V_PHY_WIDTH-1:0]     y_q, y_d;
  logic [AW-1:0]              rowbase_q, rowbase_d;

  logic [NUM_REQ-1:0]         oack_q, oack_d;
  logic [NUM_REQ-1:0]         odone_q, odone_d;
  logic                       obusy_q, obusy_d;
  logic                       owren_q, owren_d;
  logic [AW-1:0]              oaddr_q, oaddr_d;
  logic [COLOR_ID_WIDTH-1:0]  odata_q, odata_d;

  // Fields of the granted requester, valid while in LOAD.
  logic [H_PHY_WIDTH-1:0]     sel_tlx, sel_brx;
  logic [V_PHY_WIDTH-1:0]     sel_tly, sel_bry;
  logic [COLOR_ID_WIDTH-1:0]  sel_color;
  logic [H_PHY_WIDTH-1:0]     ld_brx;
  logic [V_PHY_WIDTH-1:0]     ld_bry;
  logic                       ld_empty;

  logic                       arb_hit;
  logic [GW-1:0]              arb_idx;

  // y*H_PIXELS built from the set bits of the constant stride, so it
  // reduces to a handful of shifted adds rather than a multiplier.
  function automatic logic [AW-1:0] row_of(input logic [V_PHY_WIDTH-1:0] y);
    logic [AW-1:0] acc;
    acc = '0;
    for (int unsigned b = 0; b < 32; b++) begin
      if (HP_BITS[b]) acc = acc + (AW'(y) << b);
    end
    return acc;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [GW-1:0] g);
    logic [NUM_REQ-1:0] oh;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      oh[i] = (g == GW'(i));
    end
    return oh;
  endfunction

  // Round-robin: search starts just after the last grant and wraps.
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = last_q;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      int unsigned idx;
      idx = int'(last_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!arb_hit && ireq[idx]) begin
        arb_hit = 1'b1;
        arb_idx = GW'(idx);
      end
    end
  end

  always_comb begin
    sel_tlx   = '0;
    sel_tly   = '0;
    sel_brx   = '0;
    sel_bry   = '0;
    sel_color = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (g_q == GW'(i)) begin
        sel_tlx   = itlx[i*H_PHY_WIDTH +: H_PHY_WIDTH];
        sel_tly   = itly[i*V_PHY_WIDTH +: V_PHY_WIDTH];
        sel_brx   = ibrx[i*H_PHY_WIDTH +: H_PHY_WIDTH];
        sel_bry   = ibry[i*V_PHY_WIDTH +: V_PHY_WIDTH];
        sel_color = icolor[i*COLOR_ID_WIDTH +: COLOR_ID_WIDTH];
      end
    end
  end

`ifdef FB_FILL_CLIP_EN
  always_comb begin
    ld_brx   = (sel_brx > H_PHY_WIDTH'(H_PHY_MAX)) ? H_PHY_WIDTH'(H_PHY_MAX) : sel_brx;
    ld_bry   = (sel_bry > V_PHY_WIDTH'(V_PHY_MAX)) ? V_PHY_WIDTH'(V_PHY_MAX) : sel_bry;
    ld_empty = (sel_tlx > ld_brx) || (sel_tly > ld_bry);
  end
`else
  always_comb begin
    ld_brx   = sel_brx;
    ld_bry   = sel_bry;
    ld_empty = 1'b0;
  end
`endif

  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    last_d    = last_q;
    tlx_d     = tlx_q;
    brx_d     = brx_q;
    bry_d     = bry_q;
    color_d   = color_q;
    x_d       = x_q;
    y_d       = y_q;
    rowbase_d = rowbase_q;

    unique case (state_q)
      IDLE: begin
        if (arb_hit) begin
          g_d     = arb_idx;
          state_d = LOAD;
        end
      end
      LOAD: begin
        tlx_d     = sel_tlx;
        brx_d     = ld_brx;
        bry_d     = ld_bry;
        color_d   = sel_color;
        x_d       = sel_tlx;
        y_d       = sel_tly;
        rowbase_d = row_of(sel_tly);
        last_d    = g_q;
        state_d   = ld_empty ? DONE : FILL;
      end
      FILL: begin
        if (x_q == brx_q) begin
          if (y_q == bry_q) begin
            state_d = DONE;
          end else begin
            x_d       = tlx_q;
            y_d       = y_q + V_PHY_WIDTH'(1);
            rowbase_d = rowbase_q + AW'(H_PIXELS);
          end
        end else begin
          x_d = x_q + H_PHY_WIDTH'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next-state view, so the write port
  // shows the pixel held in x/y/rowbase during every FILL cycle.
  always_comb begin
    owren_d = (state_d == FILL);
    oaddr_d = owren_d ? (rowbase_d + AW'(x_d)) : '0;
    odata_d = owren_d ? color_d : '0;
    oack_d  = (state_d == LOAD) ? onehot(g_d) : '0;
    odone_d = (state_d == DONE) ? onehot(g_q) : '0;
    obusy_d = (state_d != IDLE);
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q   <= IDLE;
      g_q       <= '0;
      last_q    <= GW'(NUM_REQ - 1);
      tlx_q     <= '0;
      brx_q     <= '0;
      bry_q     <= '0;
      color_q   <= '0;
      x_q       <= '0;
      y_q       <= '0;
      rowbase_q <= '0;
      oack_q    <= '0;
      odone_q   <= '0;
      obusy_q   <= 1'b0;
      owren_q   <= 1'b0;
      oaddr_q   <= '0;
      odata_q   <= '0;
    end else begin
      state_q   <= state_d;
      g_q       <= g_d;
      last_q    <= last_d;
      tlx_q     <= tlx_d;
      brx_q     <= brx_d;
      bry_q     <= bry_d;
      color_q   <= color_d;
      x_q       <= x_d;
      y_q       <= y_d;
      rowbase_q <= rowbase_d;
      oack_q    <= oack_d;
      odone_q   <= odone_d;
      obusy_q   <= obusy_d;
      owren_q   <= owren_d;
      oaddr_q   <= oaddr_d;
      odata_q   <= odata_d;
    end
  end

  assign oack  = oack_q;
  assign odone = odone_q;
  assign obusy = obusy_q;
  assign owren = owren_q;
  assign oaddr = oaddr_q;
  assign odata = odata_q;

endmodule

// File: tb/tb_fb_fill_arbiter.sv
// Directed bench for fb_fill_arbiter in its default build (two requesters,
// 640x480 framebuffer, clipping disabled).

module tb_fb_fill_arbiter;

  localparam int NR = 2;
  localparam int HW = 10;
  localparam int VW = 9;
  localparam int AW = 19;
  localparam int CW = 8;

  logic                  iCLK;
  logic                  iRST_n;
  logic [NR-1:0]         ireq;
  logic [NR*HW-1:0]      itlx;
  logic [NR*VW-1:0]      itly;
  logic [NR*HW-1:0]      ibrx;
  logic [NR*VW-1:0]      ibry;
  logic [NR*CW-1:0]      icolor;
  logic [NR-1:0]         oack;
  logic [NR-1:0]         odone;
  logic                  obusy;
  logic                  owren;
  logic [AW-1:0]         oaddr;
  logic [CW-1:0]         odata;

  int unsigned n_total;
  int unsigned n_bad;

  fb_fill_arbiter #(
    .NUM_REQ        (NR),
    .H_PHY_WIDTH    (HW),
    .V_PHY_WIDTH    (VW),
    .H_PIXELS       (640),
    .H_PHY_MAX      (639),
    .V_PHY_MAX      (479),
    .VGA_ADDR_WIDTH (AW),
    .COLOR_ID_WIDTH (CW)
  ) dut (
    .iCLK   (iCLK),
    .iRST_n (iRST_n),
    .ireq   (ireq),
    .itlx   (itlx),
    .itly   (itly),
    .ibrx   (ibrx),
    .ibry   (ibry),
    .icolor (icolor),
    .oack   (oack),
    .odone  (odone),
    .obusy  (obusy),
    .owren  (owren),
    .oaddr  (oaddr),
    .odata  (odata)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance one clock and sample just after the edge.
  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic set_req(input int i, input int tlx, input int tly,
                         input int brx, input int bry, input int col);
    itlx[i*HW +: HW]   = HW'(tlx);
    itly[i*VW +: VW]   = VW'(tly);
    ibrx[i*HW +: HW]   = HW'(brx);
    ibry[i*VW +: VW]   = VW'(bry);
    icolor[i*CW +: CW] = CW'(col);
  endtask

  task automatic do_reset();
    ireq   = '0;
    iRST_n = 1'b0;
    repeat (2) @(posedge iCLK);
    @(negedge iCLK);
    iRST_n = 1'b1;
    #1;
  endtask

  logic [31:0] ack_q[$];
  logic [31:0] done_q[$];
  logic [31:0] addr_q[$];
  logic [31:0] exp_ack[4];
  logic [31:0] exp_addr[6];
  int          nwr;
  int          cyc;
  logic [31:0] last_addr;

  initial begin
    n_total = 0;
    n_bad   = 0;
    ireq    = '0;
    itlx    = '0;
    itly    = '0;
    ibrx    = '0;
    ibry    = '0;
    icolor  = '0;
    iRST_n  = 1'b1;
    #2;
    do_reset();

    // Reset state
    check("rst_oack",  32'(oack),  0);
    check("rst_odone", 32'(odone), 0);
    check("rst_obusy", 32'(obusy), 0);
    check("rst_owren", 32'(owren), 0);
    check("rst_oaddr", 32'(oaddr), 0);
    check("rst_odata", 32'(odata), 0);

    // Single 2x2 fill by requester 0
    set_req(0, 0, 0, 1, 1, 8'h0F);
    ireq = 2'b01;
    step();
    check("f2_ack",   32'(oack),  32'b01);
    check("f2_busy",  32'(obusy), 1);
    check("f2_nowr",  32'(owren), 0);
    ireq = 2'b00;
    step(); check("f2_wr0", 32'(owren), 1); check("f2_a0", 32'(oaddr), 0);   check("f2_d0", 32'(odata), 32'h0F);
    step(); check("f2_wr1", 32'(owren), 1); check("f2_a1", 32'(oaddr), 1);   check("f2_d1", 32'(odata), 32'h0F);
    step(); check("f2_wr2", 32'(owren), 1); check("f2_a2", 32'(oaddr), 640); check("f2_d2", 32'(odata), 32'h0F);
    step(); check("f2_wr3", 32'(owren), 1); check("f2_a3", 32'(oaddr), 641); check("f2_d3", 32'(odata), 32'h0F);
    step();
    check("f2_done",   32'(odone), 32'b01);
    check("f2_dnowr",  32'(owren), 0);
    check("f2_dbusy",  32'(obusy), 1);
    step();
    check("f2_idle",   32'(obusy), 0);
    check("f2_done0",  32'(odone), 0);

    // Corner pixel by requester 1
    set_req(1, 639, 479, 639, 479, 8'hFF);
    ireq = 2'b10;
    step();
    check("cp_ack", 32'(oack), 32'b10);
    ireq = 2'b00;
    step();
    check("cp_wr",   32'(owren), 1);
    check("cp_addr", 32'(oaddr), 307199);
    check("cp_data", 32'(odata), 32'hFF);
    step();
    check("cp_done",  32'(odone), 32'b10);
    check("cp_nowr",  32'(owren), 0);

    // Contention: both requesting continuously from reset
    do_reset();
    set_req(0, 10, 2, 11, 2, 8'h11);
    set_req(1, 5, 1, 5, 1, 8'h22);
    exp_ack  = '{32'b01, 32'b10, 32'b01, 32'b10};
    exp_addr = '{1290, 1291, 645, 1290, 1291, 645};
    ack_q.delete(); done_q.delete(); addr_q.delete();
    ireq = 2'b11;
    for (int c = 0; c < 17; c++) begin
      step();
      if (oack != 0)  ack_q.push_back(32'(oack));
      if (odone != 0) done_q.push_back(32'(odone));
      if (owren)      addr_q.push_back(32'(oaddr));
      check("ct_overlap", 32'(owren && (oack != 0 || odone != 0)), 0);
    end
    ireq = 2'b00;
    check("ct_nack",  ack_q.size(),  4);
    check("ct_ndone", done_q.size(), 4);
    check("ct_nwr",   addr_q.size(), 6);
    for (int i = 0; i < 4; i++) begin
      if (i < ack_q.size())  check("ct_ack",  ack_q[i],  exp_ack[i]);
      if (i < done_q.size()) check("ct_done", done_q[i], exp_ack[i]);
    end
    for (int i = 0; i < 6; i++) begin
      if (i < addr_q.size()) check("ct_addr", addr_q[i], exp_addr[i]);
    end
    step();
    check("ct_idle", 32'(obusy), 0);

    // Reset during the third write of a 4x4 fill, request still held
    do_reset();
    set_req(0, 0, 0, 3, 3, 8'h33);
    ireq = 2'b01;
    step(); check("rm_ack", 32'(oack), 32'b01);
    step(); check("rm_a0", 32'(oaddr), 0);
    step(); check("rm_a1", 32'(oaddr), 1);
    step(); check("rm_a2", 32'(oaddr), 2);
    #2;
    iRST_n = 1'b0;
    #1;
    check("rm_wr",   32'(owren), 0);
    check("rm_busy", 32'(obusy), 0);
    check("rm_addr", 32'(oaddr), 0);
    check("rm_done", 32'(odone), 0);
    @(negedge iCLK);
    iRST_n = 1'b1;
    step();
    check("rm_reack", 32'(oack), 32'b01);
    check("rm_rdone", 32'(odone), 0);
    ireq = 2'b00;
    nwr = 0;
    last_addr = '0;
    cyc = 0;
    while (odone == 0 && cyc < 40) begin
      step();
      cyc++;
      if (owren) begin
        nwr++;
        last_addr = 32'(oaddr);
      end
    end
    check("rm_timeout", 32'(cyc < 40), 1);
    check("rm_fdone",   32'(odone), 32'b01);
    check("rm_nwr",     32'(nwr), 16);
    check("rm_last",    last_addr, 1923);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
